pot_scan_ctrl: RTL
==================

# pot_scan_ctrl

Round-robin scheduler that owns the shared A2D converter and keeps the six equalizer slider/volume values current. It issues one conversion request at a time over a start/complete handshake, selects the converter channel for each pot, and captures results into six registers. Those registers drive `POT_LP`, `POT_B1`, `POT_B2`, `POT_B3`, `POT_HP` and `POT_VOL` of the EQ engine.

## Interface
- `SCAN_GAP`, 16: idle cycles between the end of one conversion and the next `strt_cnv`. Legal range is 0–255.
- `TIMEOUT`, 4096: maximum `WAIT` cycles before a conversion is abandoned. Legal range is 1–65535.
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `strt_cnv`  out  1  one-cycle request to the A2D.
- `chnnl`  out  3  A2D channel for the current request.
- `cnv_cmplt`  in  1  one-cycle A2D completion strobe.
- `res`  in  12  A2D result; valid when `cnv_cmplt`=1.
- `POT_LP`, `POT_B1`, `POT_B2`, `POT_B3`, `POT_HP`, `POT_VOL`  out  12 each  registered pot values.
- `scan_done`  out  1  one-cycle pulse after index 5 completes or times out.
- `tmo`  out  1  one-cycle pulse when a conversion is abandoned.

## Operation
- **Index order:** the 3-bit index runs 0→5 and wraps 5→0.
  - Index 0 = LP (ch 1), 1 = B1 (ch 0), 2 = B2 (ch 4), 3 = B3 (ch 2), 4 = HP (ch 3), 5 = VOL (ch 7).
  - `chnnl` is a registered decode of the index.
- **State `GAP`:**
  - Cycle counter `gcnt` clears on entry.
  - When `gcnt`==`SCAN_GAP`, assert `strt_cnv` for that cycle and go to `WAIT`.
  - Otherwise increment `gcnt`.
  - `cnv_cmplt` is ignored in `GAP`, including in the `strt_cnv` cycle.
- **State `WAIT`:**
  - Counter `wcnt` clears on entry and increments every cycle.
  - On `cnv_cmplt`=1: write the pot register for the current index, advance the index, return to `GAP`.
  - Else if `wcnt`==`TIMEOUT`-1: pulse `tmo`, leave the pot unchanged, advance the index, return to `GAP`.
  - If `cnv_cmplt` arrives in the timeout cycle, the capture wins and `tmo` stays 0.
- **`scan_done`:** registered; it pulses the cycle after leaving `WAIT` with index 5, whether by capture or by timeout.
- **`chnnl` stability:** `chnnl` must not change while in `WAIT`. It updates only on index advance.
- **Width rule:** `res` is stored unsigned and zero-extended nowhere. All pot paths are exactly 12 bits.

## Timing
- **Reset values:**
  - State `GAP`, index 0, `gcnt`=0.
  - `strt_cnv`=0, `chnnl`=3'd1, `scan_done`=0, `tmo`=0.
  - All six POT outputs 12'h000; all first-load flags set.
- **First request:** the first `strt_cnv` is high in cycle `SCAN_GAP` after reset deassertion, where cycle 0 is the first rising edge with `rst_n`=1.
- **Capture latency:** a POT output updates on the edge where `cnv_cmplt`=1 and is visible the next cycle. `strt_cnv` for the next channel follows `SCAN_GAP`+1 cycles later.
- **Back-to-back requests:** with `SCAN_GAP`=0, the next `strt_cnv` asserts the first cycle after capture.
- **Full sweep period:** 6·(`SCAN_GAP`+1+L) cycles, where L is A2D latency measured in `WAIT` cycles.
- **Reset during `WAIT`:** all state returns to reset values immediately. A late `cnv_cmplt` arriving after release lands in `GAP` and is ignored.
- **Spurious strobes:** any `cnv_cmplt` outside `WAIT` is dropped with no side effect.

## Configuration
- **Macro:** `POT_AVG_EN`.
- **Defined:**
  - Each capture stores (old + `res` + 1) >> 1, computed in 13 bits and truncated to 12.
  - The first capture of each pot after reset loads `res` directly and clears that pot's first-load flag.
  - Timeouts do not clear the flag.
- **Undefined:** every capture loads `res` directly, and the first-load flags are not implemented.

## Test plan
- **Reset and first sweep:** `SCAN_GAP`=16; A2D model answers 10 cycles after `strt_cnv` with `res`=12'h100·(ch+1).
  - First `strt_cnv` occurs at cycle 16 with `chnnl`=1.
  - `chnnl` sequence is 1,0,4,2,3,7.
  - Values: `POT_LP`=12'h200, `POT_B1`=12'h100, `POT_B2`=12'h500, `POT_B3`=12'h300, `POT_HP`=12'h400, `POT_VOL`=12'h800.
  - One `scan_done` pulse after `POT_VOL` updates.
- **Timeout:** `TIMEOUT`=64; suppress `cnv_cmplt` for index 2.
  - `tmo` pulses at `WAIT` cycle 63.
  - `POT_B2` keeps its prior value; next `chnnl`=2.
  - `cnv_cmplt` in the timeout cycle instead captures, and `tmo`=0.
- **Spurious strobes:** assert `cnv_cmplt` (`res`=12'hFFF) in `GAP` and in the `strt_cnv` cycle.
  - No POT changes, no index change.
  - The next valid completion is captured normally.
- **Reset mid-`WAIT`:** drop `rst_n` 3 cycles after `strt_cnv` for index 4.
  - All outputs return to reset values.
  - `chnnl`=1 and the first request reissues at cycle `SCAN_GAP`.
- **`POT_AVG_EN` averaging:** `POT_AVG_EN` defined; feed LP 12'h000 then 12'hFFF, then 12'hFFF.
  - `POT_LP` sequence is 12'h000, 12'h800, 12'hC00.
  - Undefined build gives 12'h000, 12'hFFF, 12'hFFF.
- **Back-to-back:** `SCAN_GAP`=0; A2D answers 1 cycle after `strt_cnv`.
  - `strt_cnv` period is 3 cycles.
  - `scan_done` every 18 cycles.

Source files
------------

// File: rtl/pot_scan_ctrl.sv
// pot_scan_ctrl: round-robin A2D scheduler for the six EQ pot registers.
// Define POT_AVG_EN to average each capture with the stored value.
module pot_scan_ctrl #(
  parameter int unsigned SCAN_GAP = 16,
  parameter int unsigned TIMEOUT  = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic [11:0] POT_LP,
  output logic [11:0] POT_B1,
  output logic [11:0] POT_B2,
  output logic [11:0] POT_B3,
  output logic [11:0] POT_HP,
  output logic [11:0] POT_VOL,
  output logic        scan_done,
  output logic        tmo
);

  typedef enum logic {
    S_GAP,
    S_WAIT
  } state_e;

  localparam logic [7:0]  GAP_LAST = 8'(SCAN_GAP);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  gcnt_q, gcnt_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        strt_q, strt_d;
  logic [2:0]  chnnl_q, chnnl_d;
  logic        done_q, done_d;
  logic        tmo_q, tmo_d;
  logic [11:0] pot_q [6];
  logic [11:0] pot_d [6];
  logic        capture;
  logic        advance;
  logic [2:0]  idx_next;
`ifdef POT_AVG_EN
  logic [5:0]  first_q, first_d;

  function automatic logic [11:0] avg12(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] s;
    s = {1'b0, a} + {1'b0, b} + 13'd1;
    return s[12:1];
  endfunction
`endif

  function automatic logic [2:0] ch_of(input logic [2:0] i);
    case (i)
      3'd0:    return 3'd1;
      3'd1:    return 3'd0;
      3'd2:    return 3'd4;
      3'd3:    return 3'd2;
      3'd4:    return 3'd3;
      3'd5:    return 3'd7;
      default: return 3'd1;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    gcnt_d   = gcnt_q;
    wcnt_d   = wcnt_q;
    strt_d   = 1'b0;
    chnnl_d  = chnnl_q;
    done_d   = 1'b0;
    tmo_d    = 1'b0;
    pot_d    = pot_q;
    capture  = 1'b0;
    advance  = 1'b0;
    idx_next = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
`ifdef POT_AVG_EN
    first_d  = first_q;
`endif

    case (state_q)
      S_GAP: begin
        if (gcnt_q == GAP_LAST) begin
          strt_d  = 1'b1;
          wcnt_d  = '0;
          state_d = S_WAIT;
        end else begin
          gcnt_d = gcnt_q + 8'd1;
        end
      end
      S_WAIT: begin
        wcnt_d = wcnt_q + 16'd1;
        // strt_q marks the request cycle, where a strobe still belongs to GAP
        if (cnv_cmplt && !strt_q) begin
          capture = 1'b1;
          advance = 1'b1;
        end else if (wcnt_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          advance = 1'b1;
        end
      end
      default: state_d = S_GAP;
    endcase

    if (advance) begin
      idx_d   = idx_next;
      chnnl_d = ch_of(idx_next);
      done_d  = (idx_q == 3'd5);
      gcnt_d  = '0;
      state_d = S_GAP;
    end

    for (int unsigned i = 0; i < 6; i++) begin
      if (capture && idx_q == 3'(i)) begin
`ifdef POT_AVG_EN
        pot_d[i]   = first_q[i] ? res : avg12(pot_q[i], res);
        first_d[i] = 1'b0;
`else
        pot_d[i] = res;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_GAP;
      idx_q   <= '0;
      gcnt_q  <= '0;
      wcnt_q  <= '0;
      strt_q  <= 1'b0;
      chnnl_q <= 3'd1;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      for (int unsigned i = 0; i < 6; i++) begin
        pot_q[i] <= '0;
      end
`ifdef POT_AVG_EN
      first_q <= '1;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gcnt_q  <= gcnt_d;
      wcnt_q  <= wcnt_d;
      strt_q  <= strt_d;
      chnnl_q <= chnnl_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      pot_q   <= pot_d;
`ifdef POT_AVG_EN
      first_q <= first_d;
`endif
    end
  end

  assign strt_cnv  = strt_q;
  assign chnnl     = chnnl_q;
  assign scan_done = done_q;
  assign tmo       = tmo_q;
  assign POT_LP    = pot_q[0];
  assign POT_B1    = pot_q[1];
  assign POT_B2    = pot_q[2];
  assign POT_B3    = pot_q[3];
  assign POT_HP    = pot_q[4];
  assign POT_VOL   = pot_q[5];

endmodule
